display_arbiter: RTL and testbench

Shares the 2-digit multiplexed 7-segment display between three requesters: alert (highest priority), deposit/withdraw preview, and account balance (background). The block sits between atm_fsm/bcd_converter and the board display pins and replaces the ad-hoc display mux. It owns the refresh counter, digit selection, glyph decode, source priority, minimum-hold timing and timed alert messages.

---
 rtl/display_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_display_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/display_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | display_arbiter: priority/hold arbiter and 2-digit 7-seg mux for the ATM.   |
// | Option LEADING_ZERO_BLANK_EN blanks a zero tens digit in BAL. Rev 1.0       |
// +-----------------------------------------------------------------------------+
module display_arbiter #(
  parameter int REFRESH_BITS = 16,
  parameter int MIN_HOLD     = 1000,
  parameter int ALERT_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bal_valid,
  input  logic [7:0] bal_digits,
  input  logic       prev_req,
  input  logic [3:0] prev_digit,
  input  logic       alert_pulse,
  input  logic [7:0] alert_code,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic [2:0] grant,
  output logic       alert_active,
  output logic       digit_select
);

  localparam int HOLD_W  = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
  localparam int TIMER_W = (ALERT_CYCLES > 1) ? $clog2(ALERT_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(MIN_HOLD - 1);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(ALERT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_BLANK = 2'd0,
    ST_BAL   = 2'd1,
    ST_PREV  = 2'd2,
    ST_ALERT = 2'd3
  } state_t;

  state_t                 state_q, state_d, target;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic [TIMER_W-1:0]     timer_q, timer_d;
  logic [REFRESH_BITS-1:0] refresh_q, refresh_d;
  logic                   dsel_q, dsel_d;
  logic [7:0]             bal_q, bal_d;
  logic [3:0]             prev_q, prev_d;
  logic [7:0]             code_q, code_d;
  logic [6:0]             seg_q, seg_d;
  logic [1:0]             an_q, an_d;
  logic [2:0]             grant_q, grant_d;
  logic                   alert_active_q, alert_active_d;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'h0: decode = 7'b0111111;
      4'h1: decode = 7'b0000110;
      4'h2: decode = 7'b1011011;
      4'h3: decode = 7'b1001111;
      4'h4: decode = 7'b1100110;
      4'h5: decode = 7'b1101101;
      4'h6: decode = 7'b1111101;
      4'h7: decode = 7'b0000111;
      4'h8: decode = 7'b1111111;
      4'h9: decode = 7'b1101111;
      4'hA: decode = 7'b1110111;
      4'hB: decode = 7'b1111100;
      4'hC: decode = 7'b0111001;
      4'hD: decode = 7'b1011110;
      4'hE: decode = 7'b1111001;
      default: decode = 7'b1110001;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    timer_d   = timer_q;
    bal_d     = bal_q;
    prev_d    = prev_q;
    code_d    = code_q;
    refresh_d = refresh_q + 1'b1;
    dsel_d    = (&refresh_q) ? ~dsel_q : dsel_q;

    if (prev_req)       target = ST_PREV;
    else if (bal_valid) target = ST_BAL;
    else                target = ST_BLANK;

    if (alert_pulse) begin
      state_d = ST_ALERT;
      timer_d = TIMER_LOAD;
      code_d  = alert_code;
    end else if (state_q == ST_ALERT) begin
      if (timer_q == '0) begin
        state_d = target;
        hold_d  = HOLD_LOAD;
      end else begin
        timer_d = timer_q - 1'b1;
      end
    end else if (hold_q != '0) begin
      hold_d = hold_q - 1'b1;
    end else if (target != state_q) begin
      state_d = target;
      hold_d  = HOLD_LOAD;
    end

    // Capture on entry as well as while resident, so the first displayed frame is fresh.
    if (state_d == ST_BAL && bal_valid)  bal_d  = bal_digits;
    if (state_d == ST_PREV && prev_req)  prev_d = prev_digit;
  end

  always_comb begin
    seg_d          = 7'b0;
    an_d           = 2'b00;
    grant_d        = 3'b000;
    alert_active_d = 1'b0;
    case (state_q)
      ST_BAL: begin
        grant_d = 3'b001;
        if (dsel_q) begin
          an_d  = 2'b10;
          seg_d = decode(bal_q[7:4]);
`ifdef LEADING_ZERO_BLANK_EN
          if (bal_q[7:4] == 4'h0) begin
            an_d  = 2'b00;
            seg_d = 7'b0;
          end
`endif
        end else begin
          an_d  = 2'b01;
          seg_d = decode(bal_q[3:0]);
        end
      end
      ST_PREV: begin
        grant_d = 3'b010;
        an_d    = 2'b10;
        seg_d   = decode(prev_q);
      end
      ST_ALERT: begin
        grant_d        = 3'b100;
        alert_active_d = 1'b1;
        an_d           = dsel_q ? 2'b10 : 2'b01;
        seg_d          = dsel_q ? decode(code_q[7:4]) : decode(code_q[3:0]);
      end
      default: begin
        seg_d = 7'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_BLANK;
      hold_q         <= '0;
      timer_q        <= '0;
      refresh_q      <= '0;
      dsel_q         <= 1'b0;
      bal_q          <= 8'h00;
      prev_q         <= 4'h0;
      code_q         <= 8'h00;
      seg_q          <= 7'b0;
      an_q           <= 2'b00;
      grant_q        <= 3'b000;
      alert_active_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_q         <= hold_d;
      timer_q        <= timer_d;
      refresh_q      <= refresh_d;
      dsel_q         <= dsel_d;
      bal_q          <= bal_d;
      prev_q         <= prev_d;
      code_q         <= code_d;
      seg_q          <= seg_d;
      an_q           <= an_d;
      grant_q        <= grant_d;
      alert_active_q <= alert_active_d;
    end
  end

  assign seg          = seg_q;
  assign an           = an_q;
  assign grant        = grant_q;
  assign alert_active = alert_active_q;
  assign digit_select = dsel_q;

endmodule
`default_nettype wire

// File: tb/tb_display_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_display_arbiter: vector table plus directed sequences for the arbiter.   |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_display_arbiter;

  logic       clk;
  logic       rst;
  logic       bal_valid;
  logic [7:0] bal_digits;
  logic       prev_req;
  logic [3:0] prev_digit;
  logic       alert_pulse;
  logic [7:0] alert_code;
  logic [6:0] seg;
  logic [1:0] an;
  logic [2:0] grant;
  logic       alert_active;
  logic       digit_select;

  int checks = 0;
  int errors = 0;

  display_arbiter #(
    .REFRESH_BITS(2),
    .MIN_HOLD    (4),
    .ALERT_CYCLES(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bal_valid   (bal_valid),
    .bal_digits  (bal_digits),
    .prev_req    (prev_req),
    .prev_digit  (prev_digit),
    .alert_pulse (alert_pulse),
    .alert_code  (alert_code),
    .seg         (seg),
    .an          (an),
    .grant       (grant),
    .alert_active(alert_active),
    .digit_select(digit_select)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [1:0] LZ_AN  = 2'b00;
  localparam logic [6:0] LZ_SEG = 7'b0000000;
`else
  localparam logic [1:0] LZ_AN  = 2'b10;
  localparam logic [6:0] LZ_SEG = 7'b0111111;
`endif

  // mode: 0 blank, 1 multiplexed two-slot, 2 preview (fixed tens slot)
  typedef struct {
    logic       bv;
    logic [7:0] bd;
    logic       pr;
    logic [3:0] pd;
    logic       ap;
    logic [7:0] ac;
    int         wt;
    logic [2:0] g;
    logic       aa;
    int         mode;
    logic [6:0] s_ones;
    logic [1:0] an_tens;
    logic [6:0] s_tens;
    int         hook;
    string      name;
  } vec_t;

  vec_t vec [8];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_mode(input string name, input int mode, input logic [6:0] s_ones,
                            input logic [1:0] an_tens, input logic [6:0] s_tens);
    bit seen_ones = 0;
    bit seen_tens = 0;
    for (int s = 0; s < 6; s++) begin
      if (mode == 0) begin
        chk({name, "_blank"}, {7'b0, an, seg}, 16'h0);
      end else if (mode == 2) begin
        chk({name, "_prev"}, {7'b0, an, seg}, {7'b0, 2'b10, s_ones});
      end else begin
        if (an == 2'b01 && seg == s_ones) seen_ones = 1;
        else if (an == an_tens && seg == s_tens) seen_tens = 1;
        else chk({name, "_slot"}, {7'b0, an, seg}, {7'b0, an_tens, s_tens});
      end
      if (s < 5) step();
    end
    if (mode == 1) chk({name, "_both_slots"}, {14'b0, seen_ones, seen_tens}, 16'h3);
  endtask

  task automatic alert_count(input bit retrig, output int n);
    n = 0;
    alert_pulse = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      alert_pulse = (retrig && i == 4);
      if (alert_active) n++;
    end
    alert_pulse = 1'b0;
  endtask

  task automatic hook_refresh();
    logic [1:0] last_an;
    int first;
    bit changed;
    first   = -1;
    last_an = an;
    for (int i = 1; i <= 12; i++) begin
      step();
      changed = (an != last_an);
      if (first < 0) begin
        if (changed) first = i;
      end else begin
        chk("refresh_period", {15'b0, changed}, {15'b0, ((i - first) % 4 == 0)});
      end
      last_an = an;
    end
    chk("refresh_first_toggle", {15'b0, (first >= 1 && first <= 4)}, 16'h1);
  endtask

  task automatic hook_alerts();
    int n;
    repeat (12) step();
    alert_count(1'b0, n);
    chk("alert_len_8", 16'(n), 16'd8);
    chk("alert_exit_prev", {13'b0, grant}, 16'b010);
    alert_count(1'b1, n);
    chk("alert_retrig_13", 16'(n), 16'd13);
  endtask

  task automatic hook_prev_pulse();
    int n;
    n = 0;
    prev_req   = 1'b1;
    prev_digit = 4'h9;
    step();
    prev_req   = 1'b0;
    prev_digit = 4'h3;
    for (int i = 0; i < 12; i++) begin
      step();
      if (grant == 3'b010) begin
        n++;
        chk("prev_pulse_seg", {7'b0, an, seg}, {7'b0, 2'b10, 7'b1101111});
      end
    end
    chk("prev_pulse_hold4", 16'(n), 16'd4);
    chk("prev_pulse_back_bal", {13'b0, grant}, 16'b001);
  endtask

  initial begin
    vec[0] = '{1'b1, 8'h42, 1'b0, 4'h0, 1'b0, 8'h00, 2,  3'b001, 1'b0, 1,
               7'b1011011, 2'b10, 7'b1100110, 1, "bal_42"};
    vec[1] = '{1'b1, 8'h42, 1'b1, 4'h7, 1'b0, 8'h00, 2,  3'b010, 1'b0, 2,
               7'b0000111, 2'b10, 7'b0000111, 0, "prev_7"};
    vec[2] = '{1'b1, 8'h42, 1'b1, 4'h7, 1'b1, 8'hE1, 2,  3'b100, 1'b1, 1,
               7'b0000110, 2'b10, 7'b1111001, 2, "alert_E1"};
    vec[3] = '{1'b1, 8'h42, 1'b0, 4'h0, 1'b0, 8'h00, 3,  3'b001, 1'b0, 1,
               7'b1011011, 2'b10, 7'b1100110, 3, "back_bal"};
    vec[4] = '{1'b1, 8'h42, 1'b1, 4'h5, 1'b1, 8'h3A, 2,  3'b100, 1'b1, 1,
               7'b1110111, 2'b10, 7'b1001111, 0, "alert_vs_prev"};
    vec[5] = '{1'b1, 8'h42, 1'b1, 4'h5, 1'b0, 8'h00, 10, 3'b010, 1'b0, 2,
               7'b1101101, 2'b10, 7'b1101101, 0, "prev_after_alert"};
    vec[6] = '{1'b1, 8'h05, 1'b0, 4'h0, 1'b0, 8'h00, 3,  3'b001, 1'b0, 1,
               7'b1101101, LZ_AN, LZ_SEG, 0, "bal_05"};
    vec[7] = '{1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 8'h00, 3,  3'b000, 1'b0, 0,
               7'b0, 2'b00, 7'b0, 0, "blank"};

    rst         = 1'b1;
    bal_valid   = 1'b1;
    bal_digits  = 8'h42;
    prev_req    = 1'b1;
    prev_digit  = 4'h7;
    alert_pulse = 1'b0;
    alert_code  = 8'h00;
    #1 rst = 1'b0;
    repeat (3) step();
    chk("reset_seg",   {9'b0, seg}, 16'h0);
    chk("reset_an",    {14'b0, an}, 16'h0);
    chk("reset_grant", {13'b0, grant}, 16'h0);
    chk("reset_alert", {15'b0, alert_active}, 16'h0);
    chk("reset_dsel",  {15'b0, digit_select}, 16'h0);

    bal_valid = 1'b0;
    prev_req  = 1'b0;
    rst       = 1'b1;

    for (int k = 0; k < 8; k++) begin
      bal_valid   = vec[k].bv;
      bal_digits  = vec[k].bd;
      prev_req    = vec[k].pr;
      prev_digit  = vec[k].pd;
      alert_code  = vec[k].ac;
      alert_pulse = vec[k].ap;
      for (int w = 0; w < vec[k].wt; w++) begin
        step();
        if (w == 0) alert_pulse = 1'b0;
      end
      chk({vec[k].name, "_grant"}, {13'b0, grant}, {13'b0, vec[k].g});
      chk({vec[k].name, "_alert_active"}, {15'b0, alert_active}, {15'b0, vec[k].aa});
      check_mode(vec[k].name, vec[k].mode, vec[k].s_ones, vec[k].an_tens, vec[k].s_tens);
      case (vec[k].hook)
        1: hook_refresh();
        2: hook_alerts();
        3: hook_prev_pulse();
        default: ;
      endcase
    end

    // Asynchronous reset in the middle of an alert must blank without a clock edge.
    alert_code  = 8'h77;
    alert_pulse = 1'b1;
    step();
    alert_pulse = 1'b0;
    repeat (2) step();
    chk("pre_reset_alert", {15'b0, alert_active}, 16'h1);
    #3 rst = 1'b0;
    #1;
    chk("async_rst_grant", {13'b0, grant}, 16'h0);
    chk("async_rst_an",    {14'b0, an}, 16'h0);
    chk("async_rst_seg",   {9'b0, seg}, 16'h0);
    chk("async_rst_alert", {15'b0, alert_active}, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
